// File: rtl/points_box_filter.sv
// ---------------------------------------------------------------------------
// points_box_filter
//
// Drains (x, y, z) points from the point FIFO through its registered read
// port and forwards only those that fall inside a programmable, signed,
// inclusive axis-aligned box. Accepted points are presented on a
// valid/ready stream. Saturating pass/drop counters are kept for software.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   cfg_enable          : start / continue draining the FIFO
//   cfg_bypass          : pass every point, ignoring the box
//   cfg_min_* / max_*   : signed 16-bit inclusive bounds per axis
//   fifo_empty          : FIFO empty flag
//   fifo_rd_en          : FIFO pop request (combinational)
//   fifo_x/y/z          : FIFO registered read data (valid cycle after pop)
//   out_x/y/z           : accepted point
//   out_valid/out_ready : output stream handshake
//   pass_count          : points handed downstream (saturating)
//   drop_count          : points rejected by the box test (saturating)
//   busy                : high whenever the controller is not idle
// ---------------------------------------------------------------------------
module points_box_filter #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_enable,
   input  logic               cfg_bypass,
   input  logic [15:0]        cfg_min_x,
   input  logic [15:0]        cfg_max_x,
   input  logic [15:0]        cfg_min_y,
   input  logic [15:0]        cfg_max_y,
   input  logic [15:0]        cfg_min_z,
   input  logic [15:0]        cfg_max_z,
   input  logic               fifo_empty,
   output logic               fifo_rd_en,
   input  logic [15:0]        fifo_x,
   input  logic [15:0]        fifo_y,
   input  logic [15:0]        fifo_z,
   output logic [15:0]        out_x,
   output logic [15:0]        out_y,
   output logic [15:0]        out_z,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COUNT_W-1:0] pass_count,
   output logic [COUNT_W-1:0] drop_count,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + COUNT_W'(1);
   endfunction

   // Inclusive signed range test for one axis. A degenerate range (lo > hi)
   // can never be satisfied, so such a box rejects every point.
   function automatic logic axis_in(input logic signed [15:0] v,
                                    input logic signed [15:0] lo,
                                    input logic signed [15:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   // Capture stage: FIFO read data and bounds, interpreted as signed.
   logic signed [15:0] pt_x_p0, pt_y_p0, pt_z_p0;
   logic signed [15:0] min_x_p0, max_x_p0;
   logic signed [15:0] min_y_p0, max_y_p0;
   logic signed [15:0] min_z_p0, max_z_p0;
   logic               inside_p0;
   logic               keep_p0;
   logic               capture;
   logic               handshake;

   assign pt_x_p0  = $signed(fifo_x);
   assign pt_y_p0  = $signed(fifo_y);
   assign pt_z_p0  = $signed(fifo_z);
   assign min_x_p0 = $signed(cfg_min_x);
   assign max_x_p0 = $signed(cfg_max_x);
   assign min_y_p0 = $signed(cfg_min_y);
   assign max_y_p0 = $signed(cfg_max_y);
   assign min_z_p0 = $signed(cfg_min_z);
   assign max_z_p0 = $signed(cfg_max_z);

   assign inside_p0 = axis_in(pt_x_p0, min_x_p0, max_x_p0) &&
                      axis_in(pt_y_p0, min_y_p0, max_y_p0) &&
                      axis_in(pt_z_p0, min_z_p0, max_z_p0);
   assign keep_p0   = cfg_bypass || inside_p0;

   assign capture   = (state == CAPTURE);
   assign handshake = (state == HOLD) && out_ready;

   // out_valid is exactly the HOLD state, so an asynchronous reset drops it
   // in the same instant the state register clears.
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and pop request. Pops are also gated by cfg_enable so no new
   // point is ever taken once software has asked the block to stop; a point
   // that has already been popped still runs through CAPTURE (and HOLD).
   always_comb begin
      state_nxt  = state;
      fifo_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_enable) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            fifo_rd_en = cfg_enable && !fifo_empty;
            if (cfg_enable && !fifo_empty) begin
               state_nxt = CAPTURE;
            end else if (!cfg_enable) begin
               state_nxt = IDLE;
            end
         end
         CAPTURE: begin
            if (keep_p0) begin
               state_nxt = HOLD;
            end else begin
               state_nxt = FETCH;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt = cfg_enable ? FETCH : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output stage: load the accepted point; it stays put through HOLD and
   // after the handshake until the next accepted point replaces it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_x <= '0;
         out_y <= '0;
         out_z <= '0;
      end else if (capture && keep_p0) begin
         out_x <= fifo_x;
         out_y <= fifo_y;
         out_z <= fifo_z;
      end
   end

   // Statistics: drops are counted in CAPTURE, passes on the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_count <= '0;
         drop_count <= '0;
      end else begin
         if (capture && !keep_p0) begin
            drop_count <= sat_inc(drop_count);
         end
         if (handshake) begin
            pass_count <= sat_inc(pass_count);
         end
      end
   end

endmodule

// File: tb/tb_points_box_filter.sv
module tb_points_box_filter;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_enable = 1'b0;
   logic          cfg_bypass = 1'b0;
   logic [15:0]   cfg_min_x = '0, cfg_max_x = '0;
   logic [15:0]   cfg_min_y = '0, cfg_max_y = '0;
   logic [15:0]   cfg_min_z = '0, cfg_max_z = '0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [15:0]   fifo_x = '0, fifo_y = '0, fifo_z = '0;
   logic [15:0]   out_x, out_y, out_z;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] pass_count, drop_count;
   logic          busy;

   points_box_filter #(.COUNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_bypass(cfg_bypass),
      .cfg_min_x(cfg_min_x), .cfg_max_x(cfg_max_x),
      .cfg_min_y(cfg_min_y), .cfg_max_y(cfg_max_y),
      .cfg_min_z(cfg_min_z), .cfg_max_z(cfg_max_z),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_x(fifo_x), .fifo_y(fifo_y), .fifo_z(fifo_z),
      .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .pass_count(pass_count), .drop_count(drop_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // FIFO model with a registered read port, plus event logs.
   logic [47:0] mem    [0:63];
   int          pop_cyc[0:255];
   logic [47:0] hs_val [0:255];
   int          hs_cyc [0:255];
   int          wr_ptr = 0, rd_ptr = 0;
   int          pop_n = 0, hs_n = 0, bad_pop = 0, cyc = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (fifo_empty) begin
            bad_pop++;
         end else begin
            {fifo_x, fifo_y, fifo_z} <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
         end
         pop_cyc[pop_n % 256] = cyc;
         pop_n++;
      end
      if (out_valid && out_ready) begin
         hs_val[hs_n % 256] = {out_x, out_y, out_z};
         hs_cyc[hs_n % 256] = cyc;
         hs_n++;
      end
      cyc++;
   end

   typedef struct {
      logic [15:0] x, y, z;
      logic        keep;
   } vec_t;

   function automatic vec_t mk(input int x, input int y, input int z, input logic k);
      vec_t v;
      v.x = 16'(x); v.y = 16'(y); v.z = 16'(z); v.keep = k;
      return v;
   endfunction

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      mem[wr_ptr % 64] = {x, y, z};
      wr_ptr++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cfg_enable = 1'b0; cfg_bypass = 1'b0; out_ready = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic set_box(input int lo, input int hi);
      cfg_min_x = 16'(lo); cfg_max_x = 16'(hi);
      cfg_min_y = 16'(lo); cfg_max_y = 16'(hi);
      cfg_min_z = 16'(lo); cfg_max_z = 16'(hi);
   endtask

   task automatic wait_counts(input string nm, input int p, input int d);
      int t = 0;
      while (!(int'(pass_count) == p && int'(drop_count) == d) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_in_time"}, 64'(t < 200), 64'd1);
   endtask

   task automatic wait_hs(input string nm, input int n);
      int t = 0;
      while (hs_n < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_in_time"}, 64'(t < 200), 64'd1);
   endtask

   task automatic wait_valid(input string nm);
      int t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_valid_in_time"}, 64'(t < 50), 64'd1);
   endtask

   vec_t box_tab[4];
   vec_t deg_tab[3];

   initial begin
      int bp, bh, bad, k, t;

      box_tab[0] = mk(0, 0, 0, 1'b1);
      box_tab[1] = mk(11, 0, 0, 1'b0);
      box_tab[2] = mk(-10, 10, -10, 1'b1);
      box_tab[3] = mk(0, -11, 0, 1'b0);
      deg_tab[0] = mk(0, 0, 0, 1'b0);
      deg_tab[1] = mk(5, 1, 1, 1'b0);
      deg_tab[2] = mk(-5, -1, -1, 1'b0);

      // Asynchronous reset while a point is held.
      do_reset();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      set_box(-10, 10);
      push(16'd5, 16'd5, 16'd5);
      cfg_enable = 1'b1;
      wait_valid("rst_hold");
      tick(2);
      chk("rst_pre_out_x", 64'(out_x), 64'd5);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", 64'(out_valid), 64'd0);
      chk("rst_async_busy", 64'(busy), 64'd0);
      chk("rst_async_out", {16'd0, out_x, out_y, out_z}, 64'd0);
      chk("rst_async_counts", 64'({pass_count, drop_count}), 64'd0);
      chk("rst_async_rd_en", 64'(fifo_rd_en), 64'd0);
      cfg_enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bp = pop_n;
      push(16'd1, 16'd2, 16'd3);
      tick(5);
      chk("idle_no_pop", 64'(pop_n), 64'(bp));
      chk("idle_not_busy", 64'(busy), 64'd0);
      cfg_enable = 1'b1;
      @(negedge clk);
      chk("start_rd_en", 64'(fifo_rd_en), 64'd1);
      out_ready = 1'b1;
      wait_counts("rst_resume", 1, 0);
      chk("rst_resume_point", 64'(hs_val[(hs_n - 1) % 256]), {16'd0, 16'd1, 16'd2, 16'd3});

      // Box filter, table driven.
      do_reset();
      set_box(-10, 10);
      out_ready = 1'b1;
      bp = pop_n;
      bh = hs_n;
      for (int i = 0; i < 4; i++) push(box_tab[i].x, box_tab[i].y, box_tab[i].z);
      cfg_enable = 1'b1;
      wait_counts("box", 2, 2);
      chk("box_hs_count", 64'(hs_n - bh), 64'd2);
      k = 0;
      for (int i = 0; i < 4; i++) begin
         if (box_tab[i].keep) begin
            chk($sformatf("box_point%0d", i), 64'(hs_val[(bh + k) % 256]),
                64'({box_tab[i].x, box_tab[i].y, box_tab[i].z}));
            chk($sformatf("box_latency%0d", i),
                64'(hs_cyc[(bh + k) % 256] - pop_cyc[(bp + i) % 256]), 64'd2);
            k++;
         end
      end
      chk("box_pass_count", 64'(pass_count), 64'd2);
      chk("box_drop_count", 64'(drop_count), 64'd2);

      // Backpressure.
      do_reset();
      set_box(-10, 10);
      push(16'd3, -16'sd4, 16'd7);
      push(-16'sd1, 16'd2, -16'sd3);
      cfg_enable = 1'b1;
      wait_valid("bp");
      bp = pop_n;
      bh = hs_n;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!out_valid || fifo_rd_en ||
             {out_x, out_y, out_z} != {16'd3, 16'hFFFC, 16'd7}) bad++;
      end
      chk("bp_stable", 64'(bad), 64'd0);
      chk("bp_no_pop", 64'(pop_n), 64'(bp));
      chk("bp_no_hs", 64'(hs_n), 64'(bh));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tick(6);
      chk("bp_one_hs", 64'(hs_n - bh), 64'd1);
      chk("bp_pass_count", 64'(pass_count), 64'd1);
      chk("bp_next_held", {15'd0, out_valid, out_x, out_y, out_z},
          {15'd0, 1'b1, 16'hFFFF, 16'd2, 16'hFFFD});
      out_ready = 1'b1;
      wait_counts("bp_drain", 2, 0);

      // Empty stall and resume.
      do_reset();
      set_box(-10, 10);
      out_ready = 1'b1;
      cfg_enable = 1'b1;
      bp = pop_n;
      tick(6);
      chk("empty_busy", 64'(busy), 64'd1);
      chk("empty_no_pop", 64'(pop_n), 64'(bp));
      push(16'd7, 16'd8, 16'd9);
      #1;
      chk("empty_resume_rd_en", 64'(fifo_rd_en), 64'd1);
      wait_counts("empty", 1, 0);
      chk("empty_point", 64'(hs_val[(hs_n - 1) % 256]), {16'd0, 16'd7, 16'd8, 16'd9});

      // Degenerate box, then bypass.
      do_reset();
      set_box(-100, 100);
      cfg_min_x = 16'd5;
      cfg_max_x = 16'hFFFB;
      out_ready = 1'b1;
      bh = hs_n;
      for (int i = 0; i < 3; i++) push(deg_tab[i].x, deg_tab[i].y, deg_tab[i].z);
      cfg_enable = 1'b1;
      wait_counts("deg", 0, 3);
      chk("deg_no_output", 64'(hs_n), 64'(bh));
      cfg_bypass = 1'b1;
      for (int i = 0; i < 3; i++) push(deg_tab[i].x, deg_tab[i].y, deg_tab[i].z);
      wait_counts("bypass", 3, 3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("bypass_point%0d", i), 64'(hs_val[(bh + i) % 256]),
             64'({deg_tab[i].x, deg_tab[i].y, deg_tab[i].z}));

      // Enable dropped while a point is in CAPTURE.
      do_reset();
      set_box(-10, 10);
      out_ready = 1'b1;
      push(16'd1, 16'd1, 16'd1);
      push(16'd2, 16'd2, 16'd2);
      bp = pop_n;
      cfg_enable = 1'b1;
      t = 0;
      while (!fifo_rd_en && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("en_pop_in_time", 64'(t < 50), 64'd1);
      @(negedge clk);
      cfg_enable = 1'b0;
      wait_counts("en_drop", 1, 0);
      tick(8);
      chk("en_drop_idle", 64'(busy), 64'd0);
      chk("en_drop_one_pop", 64'(pop_n - bp), 64'd1);
      chk("en_drop_point", 64'(hs_val[(hs_n - 1) % 256]), {16'd0, 16'd1, 16'd1, 16'd1});
      cfg_enable = 1'b1;
      wait_counts("en_rest", 2, 0);

      // Counter saturation at 2^CW-1.
      do_reset();
      set_box(-10, 10);
      out_ready = 1'b1;
      bh = hs_n;
      for (int i = 0; i < 5; i++) push(16'(i), 16'(i), 16'(i));
      cfg_enable = 1'b1;
      wait_hs("sat", bh + 5);
      tick(2);
      chk("sat_pass_count", 64'(pass_count), 64'd3);
      chk("sat_drop_count", 64'(drop_count), 64'd0);

      chk("never_pop_empty", 64'(bad_pop), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
